// File: rtl/aer_event_decoder.sv
// AER input decoder: splits each AER word into channel and timestamp, extends
// the timestamp with a wrap epoch, filters by channel mask, and buffers
// accepted events in a show-ahead FIFO drained through a valid/ready handshake.
module aer_event_decoder #(
   parameter int CH_W  = 4,
   parameter int TS_W  = 20,
   parameter int EXT_W = 8,
   parameter int DEPTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [CH_W+TS_W-1:0]    aer_data,
   input  logic                    aer_valid,
   output logic                    aer_ready,
   input  logic [2**CH_W-1:0]      channel_mask,
   output logic                    ev_valid,
   input  logic                    ev_ready,
   output logic [CH_W-1:0]         ev_channel,
   output logic [EXT_W+TS_W-1:0]   ev_timestamp,
   output logic [$clog2(DEPTH):0]  fifo_level,
   output logic [CNT_W-1:0]        drop_cnt,
   output logic [CNT_W-1:0]        mask_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int ETS_W = EXT_W + TS_W;

   logic [CH_W-1:0]  in_ch;
   logic [TS_W-1:0]  in_ts;
   logic [TS_W-1:0]  last_ts;
   logic [EXT_W-1:0] epoch;
   logic [EXT_W-1:0] epoch_upd;

   logic [CH_W-1:0]  mem_ch [DEPTH];
   logic [ETS_W-1:0] mem_ts [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] rd_next;
   logic [LVL_W-1:0] level;

   logic evt;
   logic wrap;
   logic ch_en;
   logic full;
   logic push;
   logic pop;
   logic masked_evt;
   logic dropped_evt;

   assign in_ch = aer_data[CH_W+TS_W-1:TS_W];
   assign in_ts = aer_data[TS_W-1:0];

   // Event classification, wrap detection and handshake decode
   always_comb begin
      evt         = aer_valid && !rst;
      wrap        = in_ts < last_ts;
      epoch_upd   = epoch + EXT_W'(wrap);
      ch_en       = channel_mask[in_ch];
      full        = (level == LVL_W'(DEPTH));
      push        = evt && ch_en && !full;
      masked_evt  = evt && !ch_en;
      dropped_evt = evt && ch_en && full;
      pop         = (level != '0) && ev_ready;
      rd_next     = rd_ptr + PTR_W'(1);
   end

   assign aer_ready  = !rst && !full;
   assign ev_valid   = (level != '0);
   assign fifo_level = level;

   // Wrap tracker: every valid event advances last_ts, regardless of its fate
   always_ff @(posedge clk) begin
      if (rst) begin
         last_ts <= '0;
         epoch   <= '0;
      end else if (aer_valid) begin
         last_ts <= in_ts;
         epoch   <= epoch_upd;
      end
   end

   // Saturating mask and drop counters
   always_ff @(posedge clk) begin
      if (rst) begin
         mask_cnt <= '0;
         drop_cnt <= '0;
      end else begin
         if (masked_evt && (mask_cnt != '1))
            mask_cnt <= mask_cnt + CNT_W'(1);
         if (dropped_evt && (drop_cnt != '1))
            drop_cnt <= drop_cnt + CNT_W'(1);
      end
   end

   // FIFO storage write port
   always_ff @(posedge clk) begin
      if (push) begin
         mem_ch[wr_ptr] <= in_ch;
         mem_ts[wr_ptr] <= {epoch_upd, in_ts};
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_next;
         case ({push, pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

   // Registered head: the next head comes either from the incoming push (when
   // the FIFO is or becomes otherwise empty) or from the entry behind the
   // current head; it holds when the FIFO empties so outputs never go X.
   always_ff @(posedge clk) begin
      if (rst) begin
         ev_channel   <= '0;
         ev_timestamp <= '0;
      end else if (push && ((level == '0) || (pop && (level == LVL_W'(1))))) begin
         ev_channel   <= in_ch;
         ev_timestamp <= {epoch_upd, in_ts};
      end else if (pop && (level > LVL_W'(1))) begin
         ev_channel   <= mem_ch[rd_next];
         ev_timestamp <= mem_ts[rd_next];
      end
   end

endmodule

// File: tb/tb_aer_event_decoder.sv
// Self-checking bench for aer_event_decoder: a queue-based reference model is
// compared against the DUT every cycle, and directed scenarios pin literal values.
module tb_aer_event_decoder;

   localparam int CH_W  = 4;
   localparam int TS_W  = 20;
   localparam int EXT_W = 8;
   localparam int DEPTH = 8;
   localparam int CNT_W = 16;
   localparam int NCH   = 2**CH_W;
   localparam int ETS_W = EXT_W + TS_W;
   localparam int ENT_W = CH_W + ETS_W;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic [CH_W+TS_W-1:0]   aer_data = '0;
   logic                   aer_valid = 1'b0;
   logic                   aer_ready;
   logic [NCH-1:0]         channel_mask = '1;
   logic                   ev_valid;
   logic                   ev_ready = 1'b0;
   logic [CH_W-1:0]        ev_channel;
   logic [ETS_W-1:0]       ev_timestamp;
   logic [$clog2(DEPTH):0] fifo_level;
   logic [CNT_W-1:0]       drop_cnt;
   logic [CNT_W-1:0]       mask_cnt;

   int n_checks = 0;
   int n_errors = 0;

   aer_event_decoder #(
      .CH_W (CH_W),
      .TS_W (TS_W),
      .EXT_W(EXT_W),
      .DEPTH(DEPTH),
      .CNT_W(CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .aer_data    (aer_data),
      .aer_valid   (aer_valid),
      .aer_ready   (aer_ready),
      .channel_mask(channel_mask),
      .ev_valid    (ev_valid),
      .ev_ready    (ev_ready),
      .ev_channel  (ev_channel),
      .ev_timestamp(ev_timestamp),
      .fifo_level  (fifo_level),
      .drop_cnt    (drop_cnt),
      .mask_cnt    (mask_cnt)
   );

   always #5 clk = ~clk;

   // Reference model state
   logic [ENT_W-1:0] q[$];
   logic [TS_W-1:0]  m_last  = '0;
   int unsigned      m_epoch = 0;
   int unsigned      m_drop  = 0;
   int unsigned      m_mask  = 0;
   logic [ENT_W-1:0] m_head  = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model update on each rising edge
   initial forever begin
      @(posedge clk);
      if (rst) begin
         q.delete();
         m_last = '0; m_epoch = 0; m_drop = 0; m_mask = 0; m_head = '0;
      end else begin
         automatic bit room = (q.size() != DEPTH);
         automatic bit do_pop = (q.size() != 0) && ev_ready;
         automatic bit do_push = 1'b0;
         automatic logic [CH_W-1:0] ch = aer_data[CH_W+TS_W-1:TS_W];
         automatic logic [TS_W-1:0] ts = aer_data[TS_W-1:0];
         if (aer_valid) begin
            if (ts < m_last) m_epoch = (m_epoch + 1) % (2**EXT_W);
            m_last = ts;
            if (!channel_mask[ch]) begin
               if (m_mask < 2**CNT_W - 1) m_mask++;
            end else if (!room) begin
               if (m_drop < 2**CNT_W - 1) m_drop++;
            end else begin
               do_push = 1'b1;
            end
         end
         if (do_pop) void'(q.pop_front());
         if (do_push) q.push_back({ch, EXT_W'(m_epoch), ts});
         if (q.size() != 0) m_head = q[0];
      end
   end

   // Compare process: checks every output against the model on each falling edge
   initial forever begin
      @(negedge clk);
      chk("cmp_ev_valid", 64'(ev_valid), 64'(q.size() != 0));
      chk("cmp_level", 64'(fifo_level), 64'(q.size()));
      chk("cmp_aer_ready", 64'(aer_ready), 64'(!rst && (q.size() != DEPTH)));
      chk("cmp_drop_cnt", 64'(drop_cnt), 64'(m_drop));
      chk("cmp_mask_cnt", 64'(mask_cnt), 64'(m_mask));
      chk("cmp_channel", 64'(ev_channel), 64'(m_head[ENT_W-1:ETS_W]));
      chk("cmp_timestamp", 64'(ev_timestamp), 64'(m_head[ETS_W-1:0]));
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [CH_W-1:0] ch, input logic [TS_W-1:0] ts);
      aer_data  = {ch, ts};
      aer_valid = 1'b1;
      cyc();
      aer_valid = 1'b0;
   endtask

   initial begin
      // Reset and basic latency
      rst = 1'b1;
      cyc();
      chk("rst_aer_ready", 64'(aer_ready), 64'd0);
      chk("rst_ev_valid", 64'(ev_valid), 64'd0);
      chk("rst_level", 64'(fifo_level), 64'd0);
      chk("rst_timestamp", 64'(ev_timestamp), 64'd0);
      cyc();
      rst = 1'b0;
      ev_ready = 1'b1;
      send(4'h3, 20'h00010);
      chk("basic_valid", 64'(ev_valid), 64'd1);
      chk("basic_channel", 64'(ev_channel), 64'd3);
      chk("basic_ts", 64'(ev_timestamp), 64'h0000010);
      cyc();
      chk("basic_drained", 64'(fifo_level), 64'd0);
      chk("basic_hold_ch", 64'(ev_channel), 64'd3);

      // Timestamp wrap and epoch rollover
      send(4'h1, 20'hFFFF0);
      chk("wrap_first", 64'(ev_timestamp), 64'h00FFFF0);
      send(4'h1, 20'h00005);
      chk("wrap_second", 64'(ev_timestamp), 64'h0100005);
      send(4'h1, 20'h00005);
      chk("wrap_equal", 64'(ev_timestamp), 64'h0100005);
      for (int unsigned i = 0; i < 255; i++) begin
         send(4'h2, 20'h80000);
         send(4'h2, 20'h00001);
      end
      chk("wrap_rollover", 64'(ev_timestamp), 64'h0000001);
      cyc();

      // Channel mask filtering; masked events still drive wrap tracking
      channel_mask = 16'hFFF7;
      send(4'h3, 20'h00100);
      send(4'h4, 20'h00200);
      chk("mask_ch4", 64'(ev_channel), 64'd4);
      chk("mask_ts4", 64'(ev_timestamp), 64'h0000200);
      send(4'h3, 20'h00300);
      chk("mask_cnt2", 64'(mask_cnt), 64'd2);
      chk("mask_empty", 64'(ev_valid), 64'd0);
      send(4'h3, 20'h00050);
      send(4'h4, 20'h00060);
      chk("mask_wrap_ts", 64'(ev_timestamp), 64'h0100060);
      cyc();
      channel_mask = '1;

      // Fill and overflow
      ev_ready = 1'b0;
      for (int unsigned i = 0; i < 10; i++) begin
         send(CH_W'(i), 20'h01000 + TS_W'(i));
         if (i == 7) chk("full_ready_low", 64'(aer_ready), 64'd0);
      end
      chk("full_level", 64'(fifo_level), 64'd8);
      chk("full_drop", 64'(drop_cnt), 64'd2);
      ev_ready = 1'b1;
      for (int unsigned i = 0; i < 8; i++) begin
         chk("drain_ch", 64'(ev_channel), 64'(i));
         chk("drain_ts", 64'(ev_timestamp), 64'({8'h01, 20'h01000 + TS_W'(i)}));
         cyc();
      end
      chk("drain_level", 64'(fifo_level), 64'd0);

      // Simultaneous push/pop at level 4
      ev_ready = 1'b0;
      for (int unsigned k = 0; k < 4; k++) send(CH_W'(k), 20'h02000 + TS_W'(k));
      ev_ready = 1'b1;
      for (int unsigned k = 4; k < 10; k++) begin
         send(CH_W'(k), 20'h02000 + TS_W'(k));
         chk("pp_level", 64'(fifo_level), 64'd4);
      end
      for (int unsigned j = 0; j < 4; j++) begin
         chk("pp_order", 64'(ev_channel), 64'(6 + j));
         cyc();
      end

      // Push while full with a pop in the same cycle: push is dropped
      ev_ready = 1'b0;
      for (int unsigned k = 0; k < 8; k++) send(CH_W'(k), 20'h03000 + TS_W'(k));
      chk("fp_level8", 64'(fifo_level), 64'd8);
      ev_ready = 1'b1;
      send(4'h9, 20'h03009);
      chk("fp_drop", 64'(drop_cnt), 64'd3);
      chk("fp_level7", 64'(fifo_level), 64'd7);
      chk("fp_head", 64'(ev_channel), 64'd1);
      for (int unsigned j = 0; j < 7; j++) cyc();
      chk("fp_drained", 64'(fifo_level), 64'd0);

      // Reset mid-stream with an event presented during reset
      ev_ready = 1'b0;
      send(4'h1, 20'h40000);
      send(4'h1, 20'h00010);
      send(4'h1, 20'h00011);
      send(4'h1, 20'h00012);
      send(4'h1, 20'h00013);
      chk("mid_level5", 64'(fifo_level), 64'd5);
      rst = 1'b1;
      aer_data = {4'h2, 20'h00009};
      aer_valid = 1'b1;
      cyc();
      rst = 1'b0;
      aer_valid = 1'b0;
      chk("mid_level0", 64'(fifo_level), 64'd0);
      chk("mid_valid", 64'(ev_valid), 64'd0);
      chk("mid_channel", 64'(ev_channel), 64'd0);
      chk("mid_ts", 64'(ev_timestamp), 64'd0);
      chk("mid_drop", 64'(drop_cnt), 64'd0);
      ev_ready = 1'b1;
      send(4'h7, 20'h00005);
      chk("post_rst_ch", 64'(ev_channel), 64'd7);
      chk("post_rst_ts", 64'(ev_timestamp), 64'h0000005);
      cyc();
      cyc();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
